// File: rtl/ifetch_queue_if.sv
// Instruction-memory request/response channel: ifetch_queue is the master, memory the slave.
interface ifetch_queue_if #(
   parameter int XLEN = 32
);
   logic            req_valid;
   logic            req_ready;
   logic [XLEN-1:0] req_addr;
   logic            resp_valid;
   logic [XLEN-1:0] resp_inst;

   modport master (
      output req_valid, req_addr,
      input  req_ready, resp_valid, resp_inst
   );

   modport slave (
      input  req_valid, req_addr,
      output req_ready, resp_valid, resp_inst
   );
endinterface

// File: rtl/ifetch_queue.sv
// Fetch stage: issues PC requests to instruction memory and buffers in-order responses for decode.
// Optional trace output is compiled in when IFETCH_TRACE_EN is defined.
module ifetch_queue #(
   parameter int DEPTH = 2,
   parameter int XLEN  = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [XLEN-1:0]      pc_i,
   output logic                 pc_stall_o,
   input  logic                 br_ctrl_i,
   ifetch_queue_if.master       mem,
   output logic                 id_valid_o,
   output logic [XLEN-1:0]      id_pc_o,
   output logic [XLEN-1:0]      id_inst_o,
   input  logic                 id_ready_i
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   logic [XLEN-1:0] q_pc_q   [DEPTH];
   logic [XLEN-1:0] q_inst_q [DEPTH];
   logic [XLEN-1:0] pend_q   [DEPTH];
   logic [PW-1:0]   q_wr_q, q_rd_q, p_wr_q, p_rd_q;
   logic [CW-1:0]   occ_q, occ_d;
   logic [CW-1:0]   inflight_q, inflight_d;
   logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

   logic [CW+1:0]   credit_sum;
   logic            credit, issue, resp_legal, resp_drop, resp_push, pop;

   // Every fetch in flight, being dropped, or buffered holds one queue slot of credit.
   assign credit_sum     = {2'b00, inflight_q} + {2'b00, drop_cnt_q} + {2'b00, occ_q};
   assign credit         = credit_sum < (CW+2)'(DEPTH);
   assign mem.req_valid  = !rst && !br_ctrl_i && credit;
   assign mem.req_addr   = pc_i;
   assign issue          = mem.req_valid && mem.req_ready;
   assign pc_stall_o     = !issue;

   assign resp_legal = mem.resp_valid && (inflight_q != '0 || drop_cnt_q != '0);
   assign resp_drop  = !br_ctrl_i && mem.resp_valid && drop_cnt_q != '0;
   assign resp_push  = !br_ctrl_i && mem.resp_valid && drop_cnt_q == '0 && inflight_q != '0;

   assign id_valid_o = occ_q != '0;
   assign id_pc_o    = q_pc_q[q_rd_q];
   assign id_inst_o  = q_inst_q[q_rd_q];
   assign pop        = id_valid_o && id_ready_i && !br_ctrl_i;

   always_comb begin
      // NOTE: every next-state value gets a default first so no path leaves it unassigned (no latch).
      inflight_d = inflight_q;
      drop_cnt_d = drop_cnt_q;
      occ_d      = occ_q;
      if (br_ctrl_i) begin
         // Everything in flight becomes stale; a response landing this cycle is already one of them.
         inflight_d = '0;
         drop_cnt_d = drop_cnt_q + inflight_q - CW'(resp_legal);
         occ_d      = '0;
      end else begin
         inflight_d = inflight_q + CW'(issue) - CW'(resp_push);
         drop_cnt_d = drop_cnt_q - CW'(resp_drop);
         occ_d      = occ_q + CW'(resp_push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         inflight_q <= '0;
         drop_cnt_q <= '0;
         occ_q      <= '0;
         q_wr_q     <= '0;
         q_rd_q     <= '0;
         p_wr_q     <= '0;
         p_rd_q     <= '0;
         // NOTE: storage is reset on purpose so id_pc_o/id_inst_o read 0 out of reset.
         for (int i = 0; i < DEPTH; i++) begin
            q_pc_q[i]   <= '0;
            q_inst_q[i] <= '0;
            pend_q[i]   <= '0;
         end
      end else begin
         // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
         inflight_q <= inflight_d;
         drop_cnt_q <= drop_cnt_d;
         occ_q      <= occ_d;
         if (br_ctrl_i) begin
            q_wr_q <= '0;
            q_rd_q <= '0;
            p_wr_q <= '0;
            p_rd_q <= '0;
         end else begin
            if (issue) begin
               pend_q[p_wr_q] <= pc_i;
               p_wr_q         <= p_wr_q + PW'(1);
            end
            if (resp_push) begin
               q_pc_q[q_wr_q]   <= pend_q[p_rd_q];
               q_inst_q[q_wr_q] <= mem.resp_inst;
               q_wr_q           <= q_wr_q + PW'(1);
               p_rd_q           <= p_rd_q + PW'(1);
            end
            if (pop) begin
               q_rd_q <= q_rd_q + PW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && mem.resp_valid) begin
         assert (inflight_q != '0 || drop_cnt_q != '0)
            else $error("ifetch_queue: response with no fetch outstanding");
      end
   end

`ifdef IFETCH_TRACE_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (pop) begin
            $display("-----------------------");
            $display("IF: pc=%h inst=%h", id_pc_o, id_inst_o);
         end
         if (br_ctrl_i) begin
            $display("IF: flush drop=%0d", drop_cnt_d);
         end
      end
   end
`else
   // Trace disabled: no display statements are compiled.
`endif

endmodule
